// File: rtl/gelato_types.sv
// Shared types for the gelato ALU dispatcher: ALU opcodes and dispatcher FSM states.
package gelato_types;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_WB   = 2'd2
  } disp_state_t;

  localparam int ALU_OP_W = $bits(alu_op_t);
endpackage

// File: rtl/gelato_alu_task_if.sv
// Request/response channel between the dispatcher (master) and the ALU (slave).
`include "gelato_macros.svh"
interface gelato_alu_task_if import gelato_types::*; #(
  parameter int DATA_W = `GELATO_DATA_W_DEF
) ();
  logic              valid;
  alu_op_t           op;
  logic [DATA_W-1:0] rs1;
  logic [DATA_W-1:0] rs2;
  logic              done;
  logic [DATA_W-1:0] rd;

  modport master (output valid, op, rs1, rs2, input done, rd);
  modport slave  (input valid, op, rs1, rs2, output done, rd);
endinterface

// File: rtl/gelato_macros.svh
// Parameter defaults shared by the gelato ALU dispatcher slice.
`ifndef GELATO_MACROS_SVH
`define GELATO_MACROS_SVH
`define GELATO_DATA_W_DEF     32
`define GELATO_RD_IDX_W_DEF   5
`define GELATO_WARP_ID_W_DEF  3
`define GELATO_FIFO_DEPTH_DEF 4
`define GELATO_TIMEOUT_DEF    256
`endif

// File: rtl/gelato_sync_fifo.sv
// Synchronous FIFO with wrap-around pointers carrying an extra MSB for full/empty.
module gelato_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop && !empty)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/gelato_alu_dispatcher.sv
// Buffers ALU issue requests, runs them one at a time on the ALU and returns results in order.
// Optional watchdog on the ALU response is enabled by defining GELATO_ALU_TIMEOUT_EN.
`include "gelato_macros.svh"
module gelato_alu_dispatcher import gelato_types::*; #(
  parameter int DATA_W     = `GELATO_DATA_W_DEF,
  parameter int RD_IDX_W   = `GELATO_RD_IDX_W_DEF,
  parameter int WARP_ID_W  = `GELATO_WARP_ID_W_DEF,
  parameter int FIFO_DEPTH = `GELATO_FIFO_DEPTH_DEF,
  parameter int TIMEOUT    = `GELATO_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  alu_op_t              issue_op,
  input  logic [DATA_W-1:0]    issue_rs1,
  input  logic [DATA_W-1:0]    issue_rs2,
  input  logic [RD_IDX_W-1:0]  issue_rd_idx,
  input  logic [WARP_ID_W-1:0] issue_warp_id,
  gelato_alu_task_if.master    compute_task,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [DATA_W-1:0]    wb_data,
  output logic [RD_IDX_W-1:0]  wb_rd_idx,
  output logic [WARP_ID_W-1:0] wb_warp_id,
  output logic                 wb_err
);
  localparam int ENTRY_W  = ALU_OP_W + 2*DATA_W + RD_IDX_W + WARP_ID_W;
  localparam int RS2_LSB  = RD_IDX_W + WARP_ID_W;
  localparam int RS1_LSB  = RS2_LSB + DATA_W;
  localparam int OP_LSB   = RS1_LSB + DATA_W;

  disp_state_t          state_reg;
  logic                 task_valid_reg;
  alu_op_t              task_op_reg;
  logic [DATA_W-1:0]    task_rs1_reg;
  logic [DATA_W-1:0]    task_rs2_reg;
  logic [RD_IDX_W-1:0]  task_rd_idx_reg;
  logic [WARP_ID_W-1:0] task_warp_id_reg;
  logic                 wb_valid_reg;
  logic [DATA_W-1:0]    wb_data_reg;

  logic [ENTRY_W-1:0]   push_entry;
  logic [ENTRY_W-1:0]   head_entry;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;

  assign push_entry  = {issue_op, issue_rs1, issue_rs2, issue_rd_idx, issue_warp_id};
  assign issue_ready = !fifo_full;
  assign fifo_pop    = (state_reg == ST_IDLE) && !fifo_empty;

  gelato_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (issue_valid && issue_ready),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign compute_task.valid = task_valid_reg;
  assign compute_task.op    = task_op_reg;
  assign compute_task.rs1   = task_rs1_reg;
  assign compute_task.rs2   = task_rs2_reg;
  assign wb_valid           = wb_valid_reg;
  assign wb_data            = wb_data_reg;
  assign wb_rd_idx          = task_rd_idx_reg;
  assign wb_warp_id         = task_warp_id_reg;

`ifdef GELATO_ALU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wd_count_reg;
  logic             wb_err_reg;
  assign wb_err = wb_err_reg;
`else
  // Without the watchdog an error can never be raised.
  localparam logic NO_WD_ERR = (TIMEOUT < 0);
  assign wb_err = NO_WD_ERR;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      task_valid_reg   <= 1'b0;
      task_op_reg      <= ALU_ADD;
      task_rs1_reg     <= '0;
      task_rs2_reg     <= '0;
      task_rd_idx_reg  <= '0;
      task_warp_id_reg <= '0;
      wb_valid_reg     <= 1'b0;
      wb_data_reg      <= '0;
`ifdef GELATO_ALU_TIMEOUT_EN
      wd_count_reg     <= '0;
      wb_err_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            task_op_reg      <= alu_op_t'(head_entry[OP_LSB +: ALU_OP_W]);
            task_rs1_reg     <= head_entry[RS1_LSB +: DATA_W];
            task_rs2_reg     <= head_entry[RS2_LSB +: DATA_W];
            task_rd_idx_reg  <= head_entry[WARP_ID_W +: RD_IDX_W];
            task_warp_id_reg <= head_entry[WARP_ID_W-1:0];
            task_valid_reg   <= 1'b1;
            state_reg        <= ST_BUSY;
`ifdef GELATO_ALU_TIMEOUT_EN
            wd_count_reg     <= '0;
`endif
          end
        end
        ST_BUSY: begin
          if (compute_task.done) begin
            wb_data_reg    <= compute_task.rd;
            task_valid_reg <= 1'b0;
            wb_valid_reg   <= 1'b1;
            state_reg      <= ST_WB;
`ifdef GELATO_ALU_TIMEOUT_EN
            wb_err_reg     <= 1'b0;
          end else if (wd_count_reg == CNT_W'(TIMEOUT - 1)) begin
            wb_data_reg    <= '0;
            wb_err_reg     <= 1'b1;
            task_valid_reg <= 1'b0;
            wb_valid_reg   <= 1'b1;
            state_reg      <= ST_WB;
          end else begin
            wd_count_reg   <= wd_count_reg + 1'b1;
`endif
          end
        end
        ST_WB: begin
          if (wb_ready) begin
            wb_valid_reg <= 1'b0;
            state_reg    <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule
